// File: rtl/alm_log_divider.sv
// Mitchell-style approximate log-domain divider.
// Each operand is reduced to a log form: the index of its leading one plus the
// bits below that one, left-aligned. The two logs are subtracted and the
// result is converted back to a fixed-point quotient. A and B are captured in
// an input register, and three compute stages follow it. The whole pipe
// advances together unless the output is valid and not accepted.
module alm_log_divider #(
  parameter int BW      = 16,
  parameter int FRAC_BW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BW-1:0]         A,
  input  logic [BW-1:0]         B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW+FRAC_BW-1:0] quotient,
  output logic                  div_zero
);

  localparam int KW = $clog2(BW);   // leading-one index width
  localparam int EW = KW + 2;       // signed exponent width, covers -BW .. BW-1
  localparam int QW = BW + FRAC_BW;

  // Index of the most significant set bit; 0 when x is zero.
  function automatic logic [KW-1:0] lead_one(input logic [BW-1:0] x);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < BW; i++) begin
      if (x[i]) k = KW'(i);
    end
    return k;
  endfunction

  // Bits below the leading one, left-aligned into BW-1 bits.
  function automatic logic [BW-2:0] norm_frac(input logic [BW-1:0] x,
                                              input logic [KW-1:0] k);
    logic [BW-1:0] sh;
    sh = x << ((BW - 1) - int'(k));
    return sh[BW-2:0];
  endfunction

  logic stall, adv;

  // Input register
  logic          v0_q, v0_d;
  logic [BW-1:0] a0_q, a0_d, b0_q, b0_d;
  // Stage 1: log form
  logic          v1_q, v1_d;
  logic [KW-1:0] ka1_q, ka1_d, kb1_q, kb1_d;
  logic [BW-2:0] fa1_q, fa1_d, fb1_q, fb1_d;
  logic          za1_q, za1_d, zb1_q, zb1_d;
  // Stage 2: log difference
  logic                 v2_q, v2_d;
  logic [BW-2:0]        frac2_q, frac2_d;
  logic signed [EW-1:0] e2_q, e2_d;
  logic                 za2_q, za2_d, zb2_q, zb2_d;
  // Stage 3: output
  logic          out_valid_q, out_valid_d;
  logic [QW-1:0] quotient_q, quotient_d;
  logic          div_zero_q, div_zero_d;

  assign stall     = out_valid_q & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign div_zero  = div_zero_q;

  // Input capture and log conversion of the captured operands.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path leaves it unassigned and no latch is inferred.
    v0_d  = v0_q;
    a0_d  = a0_q;
    b0_d  = b0_q;
    v1_d  = v1_q;
    ka1_d = ka1_q;
    kb1_d = kb1_q;
    fa1_d = fa1_q;
    fb1_d = fb1_q;
    za1_d = za1_q;
    zb1_d = zb1_q;
    if (adv) begin
      v0_d  = in_valid;
      a0_d  = A;
      b0_d  = B;
      v1_d  = v0_q;
      ka1_d = lead_one(a0_q);
      kb1_d = lead_one(b0_q);
      fa1_d = norm_frac(a0_q, lead_one(a0_q));
      fb1_d = norm_frac(b0_q, lead_one(b0_q));
      za1_d = (a0_q == '0);
      zb1_d = (b0_q == '0);
    end
  end

  // Log-domain subtraction; a fraction borrow moves one unit out of the exponent.
  always_comb begin
    logic [BW-1:0] diff;
    logic          borrow;
    diff    = {1'b0, fa1_q} - {1'b0, fb1_q};
    borrow  = (fa1_q < fb1_q);
    v2_d    = v2_q;
    frac2_d = frac2_q;
    e2_d    = e2_q;
    za2_d   = za2_q;
    zb2_d   = zb2_q;
    if (adv) begin
      v2_d    = v1_q;
      frac2_d = diff[BW-2:0];
      e2_d    = EW'(ka1_q) - EW'(kb1_q) - EW'(borrow);
      za2_d   = za1_q;
      zb2_d   = zb1_q;
    end
  end

  // Antilog: shift the restored mantissa into the fixed-point quotient.
  always_comb begin
    logic [QW-1:0] m_ext;
    int            s;
    m_ext       = QW'({1'b1, frac2_q});
    s           = int'(e2_q) + FRAC_BW - (BW - 1);
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    div_zero_d  = div_zero_q;
    if (adv) begin
      out_valid_d = v2_q;
      div_zero_d  = zb2_q;
      if (zb2_q)      quotient_d = '1;
      else if (za2_q) quotient_d = '0;
      else if (s >= 0) quotient_d = m_ext << s;
      else            quotient_d = m_ext >> (-s);
    end
  end

  // Stage valids and visible outputs: cleared by reset, otherwise follow _d.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Datapath payload registers, qualified by the stage valids.
  always_ff @(posedge clk) begin
    // NOTE: payload flops are not reset; their contents are ignored until the matching valid is set.
    a0_q    <= a0_d;
    b0_q    <= b0_d;
    ka1_q   <= ka1_d;
    kb1_q   <= kb1_d;
    fa1_q   <= fa1_d;
    fb1_q   <= fb1_d;
    za1_q   <= za1_d;
    zb1_q   <= zb1_d;
    frac2_q <= frac2_d;
    e2_q    <= e2_d;
    za2_q   <= za2_d;
    zb2_q   <= zb2_d;
  end

endmodule

// File: tb/tb_alm_log_divider.sv
// Self-checking bench for alm_log_divider at BW=8, FRAC_BW=4.
module tb_alm_log_divider;

  localparam int BW      = 8;
  localparam int FRAC_BW = 4;
  localparam int QW      = BW + FRAC_BW;
  localparam int SCALE   = 1 << (BW - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] A = '0;
  logic [BW-1:0] B = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [QW-1:0] quotient;
  logic          div_zero;

  always #5 clk = ~clk;

  alm_log_divider #(.BW(BW), .FRAC_BW(FRAC_BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .div_zero  (div_zero)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rx_count = 0;
  int rx_cyc[$];
  logic [QW-1:0] exp_q[$];
  logic          exp_dz[$];
  bit            rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mitchell log in units of 1/SCALE: floor(log2 x) plus the linear fraction.
  function automatic int mitchell_log(input int x);
    int k;
    k = 0;
    while ((2 << k) <= x) k++;
    return k * SCALE + (x - (1 << k)) * (SCALE >> k);
  endfunction

  // Reference: subtract logs, split into integer/fraction, take linear antilog.
  function automatic void model(input int a, input int b,
                                output logic [QW-1:0] q, output logic dz);
    int     d, e, frac;
    longint val;
    if (b == 0) begin
      q  = '1;
      dz = 1'b1;
    end else if (a == 0) begin
      q  = '0;
      dz = 1'b0;
    end else begin
      d    = mitchell_log(a) - mitchell_log(b);
      e    = (d + 16 * SCALE) / SCALE - 16;
      frac = d - e * SCALE;
      val  = longint'(SCALE + frac) << (e + FRAC_BW + 16);
      q    = QW'(val >> (BW - 1 + 16));
      dz   = 1'b0;
    end
  endfunction

  // Output monitor, sampled just before the rising edge that completes a transfer.
  always begin
    @(negedge clk);
    #4;
    if (!rst && out_valid && out_ready) begin
      rx_count++;
      rx_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("quotient", quotient, exp_q.pop_front());
        check("div_zero", div_zero, exp_dz.pop_front());
      end
    end
  end

  task automatic drive_slot();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input logic [QW-1:0] eq, input logic edz);
    int guard;
    guard = 0;
    drive_slot();
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    A = BW'(a);
    B = BW'(b);
    #1;
    while (!in_ready && guard < 100) begin
      drive_slot();
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    exp_q.push_back(eq);
    exp_dz.push_back(edz);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input int a, input int b);
    logic [QW-1:0] q;
    logic          dz;
    model(a, b, q, dz);
    send(a, b, q, dz);
  endtask

  task automatic send_random();
    int a, b;
    a = $urandom_range(0, 255);
    b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
    send_model(a, b);
  endtask

  task automatic wait_rx(input int target);
    int guard;
    guard = 0;
    while (rx_count < target && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    check("rx_count", rx_count, target);
  endtask

  task automatic measure_latency();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 10);
    check("latency", n, 3);
  endtask

  int d_a[7]   = '{100, 5, 255, 1, 0, 0, 77};
  int d_b[7]   = '{7, 10, 1, 255, 9, 0, 0};
  int d_q[7]   = '{'h0E8, 'h008, 'hFF0, 'h000, 'h000, 'hFFF, 'hFFF};
  int d_dz[7]  = '{0, 0, 0, 0, 0, 1, 1};

  initial begin
    int base;

    repeat (3) @(posedge clk);
    drive_slot();
    rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_in_ready", in_ready, 1);

    // Exact case with latency measurement
    send(12, 3, 12'h040, 1'b0);
    measure_latency();
    wait_rx(1);

    // Directed cases from hand-derived values
    for (int i = 0; i < 7; i++) send(d_a[i], d_b[i], QW'(d_q[i]), 1'(d_dz[i]));
    wait_rx(8);

    // Back-to-back streaming
    base = rx_count;
    for (int i = 0; i < 20; i++) send_random();
    wait_rx(base + 20);
    check("stream_span", rx_cyc[base + 19] - rx_cyc[base], 19);

    // Backpressure: four ops, output held for five cycles
    drive_slot();
    out_ready = 1'b0;
    base = rx_count;
    for (int i = 0; i < 4; i++) send_random();
    for (int i = 0; i < 5; i++) begin
      drive_slot();
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold_quotient", quotient, exp_q[0]);
      check("bp_hold_div_zero", div_zero, exp_dz[0]);
    end
    out_ready = 1'b1;
    wait_rx(base + 4);
    check("bp_drain_span", rx_cyc[base + 3] - rx_cyc[base], 3);

    // Random traffic with random backpressure
    base = rx_count;
    rand_bp = 1'b1;
    for (int i = 0; i < 100; i++) send_random();
    rand_bp = 1'b0;
    drive_slot();
    out_ready = 1'b1;
    wait_rx(base + 100);

    // Reset with operations in flight
    drive_slot();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_random();
    drive_slot();
    rst = 1'b1;
    drive_slot();
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_quotient", quotient, 0);
    check("rst_mid_in_ready", in_ready, 1);
    rst = 1'b0;
    exp_q.delete();
    exp_dz.delete();
    out_ready = 1'b1;
    base = rx_count;
    send(12, 3, 12'h040, 1'b0);
    measure_latency();
    wait_rx(base + 1);

    repeat (6) @(posedge clk);
    check("final_rx_count", rx_count, 133);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
